// File: rtl/counter_mod_n_prog_pkg.sv
// counter_mod_n_prog_pkg
// Shared definitions for the programmable modulo-N counter: counting-mode
// encodings, one-shot FSM state encodings and a small mode helper.
package counter_mod_n_prog_pkg;

    // Counting modes as they arrive on the 2-bit mode port.
    // Encoding 11 is not a mode of its own and behaves exactly like WRAP.
    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_e;

    // One-shot sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // True for both encodings that behave as WRAP.
    function automatic logic is_wrap_mode(input mode_e m);
        return (m == MODE_WRAP) || (m == MODE_WRAP_ALT);
    endfunction

endpackage

// File: rtl/counter_mod_n_next.sv
// counter_mod_n_next
// Combinational next-count and terminal-value calculator for the
// programmable modulo-N counter. Holds no state.
//
// Ports
//   count    in   WIDTH  current registered count
//   last_q   in   WIDTH  current terminal value N-1
//   up_dn    in   1      1 = count up, 0 = count down
//   sat      in   1      1 = hold at the terminal value instead of wrapping
//   nxt      out  WIDTH  count after one enabled step
//   at_term  out  1      count sits on the terminal value for this direction
module counter_mod_n_next #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] last_q,
    input  logic             up_dn,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Up: the terminal is last_q. A count above last_q can only come from a
    // modulus that shrank underneath it, so it rolls straight back to 0.
    // Down: the terminal is 0, and anything above 0 simply decrements, even
    // when it sits above last_q.
    always_comb begin
        nxt     = count;
        at_term = 1'b0;
        if (up_dn) begin
            at_term = (count == last_q);
            if (count < last_q) begin
                nxt = count + ONE;
            end else if (count == last_q) begin
                nxt = sat ? count : '0;
            end else begin
                nxt = '0;
            end
        end else begin
            at_term = (count == '0);
            if (count != '0) begin
                nxt = count - ONE;
            end else begin
                nxt = sat ? count : last_q;
            end
        end
    end

endmodule

// File: rtl/counter_mod_n_prog.sv
// counter_mod_n_prog
// Programmable modulo-N counter used as the bit-position / cycle sequencer
// beside the serial-parallel multiplier. Supports a runtime modulus,
// up/down counting, wrap / saturate / one-shot modes, parallel load and
// synchronous clear, plus terminal-count, wrap and busy/done status.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset_n   in   1      asynchronous reset, active-low
//   clr       in   1      synchronous clear (highest priority strobe)
//   en        in   1      count enable
//   up_dn     in   1      1 = count up, 0 = count down
//   mode      in   2      00 WRAP, 01 SATURATE, 10 ONESHOT, 11 WRAP
//   last_val  in   WIDTH  terminal value N-1, sampled on clr, load or start
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  value to load (clamped to last_val)
//   start     in   1      one-shot launch strobe
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal decode: count == (up ? last_q : 0)
//   wrap      out  1      1-cycle pulse after a WRAP-mode rollover
//   busy      out  1      one-shot run in progress
//   done      out  1      1-cycle pulse when a one-shot run completes
module counter_mod_n_prog
    import counter_mod_n_prog_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int LAST_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] last_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] LAST_RESET = WIDTH'(LAST_DEFAULT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] last_q;
    state_e           state_q;
    logic             run_up_q;
    logic             wrap_q;
    logic             done_q;

    mode_e            mode_s;
    logic             eff_up;
    logic             eff_sat;
    logic [WIDTH-1:0] nxt;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    assign mode_s = mode_e'(mode);

    // During a run the direction is frozen at the value captured by start;
    // outside a run the live up_dn input steers both counting and tc.
    // A run always holds at its terminal, so it calculates as saturating.
    assign eff_up  = (state_q == ST_RUN) ? run_up_q : up_dn;
    assign eff_sat = (state_q == ST_RUN) || (mode_s == MODE_SAT);

    assign load_clamped = (load_val < last_val) ? load_val : last_val;

    counter_mod_n_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count   (count_q),
        .last_q  (last_q),
        .up_dn   (eff_up),
        .sat     (eff_sat),
        .nxt     (nxt),
        .at_term (at_term)
    );

    // Counter, modulus, one-shot FSM and pulse registers.
    // Strobes are resolved clr > load > start > en and only the winner acts.
    // A start that cannot launch (wrong mode or FSM not idle) is treated as
    // absent, so an ongoing run keeps counting on en. DONE always lasts one
    // cycle; a load in that cycle still lets the FSM fall back to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            last_q   <= LAST_RESET;
            state_q  <= ST_IDLE;
            run_up_q <= 1'b1;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            if (clr) begin
                count_q <= '0;
                last_q  <= last_val;
                state_q <= ST_IDLE;
            end else if (load) begin
                count_q <= load_clamped;
                last_q  <= last_val;
                if (state_q == ST_DONE) begin
                    state_q <= ST_IDLE;
                end
            end else if (start && (state_q == ST_IDLE) && (mode_s == MODE_ONESHOT)) begin
                count_q  <= up_dn ? '0 : last_val;
                last_q   <= last_val;
                run_up_q <= up_dn;
                state_q  <= ST_RUN;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (en && (mode_s != MODE_ONESHOT)) begin
                            count_q <= nxt;
                            if (at_term && is_wrap_mode(mode_s)) begin
                                wrap_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (en) begin
                            if (at_term) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                count_q <= nxt;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign tc    = (count_q == (eff_up ? last_q : '0));
    assign wrap  = wrap_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;

endmodule
